// File: rtl/sat_engine_pkg.sv
// Shared Sat Engine definitions: solve-loop state encoding and per-bin result codes.
package sat_engine_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_DECIDE    = 4'd2;
  localparam logic [3:0] ST_W_DECIDE  = 4'd3;
  localparam logic [3:0] ST_IMPLY     = 4'd4;
  localparam logic [3:0] ST_ANALYZE   = 4'd5;
  localparam logic [3:0] ST_W_ANALYZE = 4'd6;
  localparam logic [3:0] ST_BKT       = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD      = ST_LOAD,
    S_DECIDE    = ST_DECIDE,
    S_W_DECIDE  = ST_W_DECIDE,
    S_IMPLY     = ST_IMPLY,
    S_ANALYZE   = ST_ANALYZE,
    S_W_ANALYZE = ST_W_ANALYZE,
    S_BKT       = ST_BKT,
    S_DONE      = ST_DONE
  } solve_state_t;

  localparam logic [1:0] RES_SAT     = 2'd0;
  localparam logic [1:0] RES_BKT_OUT = 2'd1;
  localparam logic [1:0] RES_UNSAT   = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  // States that wait on a state_list response and are therefore watched by the watchdog.
  function automatic logic is_wait_state(input solve_state_t s);
    return s inside {S_IMPLY, S_W_DECIDE, S_W_ANALYZE, S_BKT};
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// Saturating 16-bit event counter with synchronous clear and count enable.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  // Count enabled events, sticking at all-ones; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= 16'd0;
    end else if (clr) begin
      count <= 16'd0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/bin_solve_ctrl.sv
// Per-bin solve-loop sequencer between the bin manager and state_list.
import sat_engine_pkg::*;

module bin_solve_ctrl #(
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_WDOG   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_bin_i,
  input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
  input  logic [WIDTH_LVL-1:0]    base_lvl_i,
  input  logic [WIDTH_LVL-1:0]    load_lvl_i,
  output logic                    done_bin_o,
  output logic [1:0]              bin_result_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic                    busy_o,
  output logic [15:0]             n_decisions_o,
  output logic [15:0]             n_conflicts_o,
  output logic                    base_lvl_en_o,
  output logic                    load_lvl_en_o,
  output logic [WIDTH_LVL-1:0]    base_lvl_o,
  output logic [WIDTH_LVL-1:0]    load_lvl_o,
  output logic                    start_decision_o,
  input  logic                    done_decision_i,
  input  logic                    all_assigned_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
  output logic                    apply_imply_o,
  input  logic                    done_imply_i,
  input  logic                    find_conflict_i,
  output logic                    apply_analyze_o,
  input  logic                    done_analyze_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  output logic                    apply_bkt_cur_bin_o,
  input  logic                    done_bkt_cur_bin_i
);

  // Watchdog fires on the edge that would take the count to all-ones.
  localparam logic [WIDTH_WDOG-1:0] WDOG_LAST = {{(WIDTH_WDOG-1){1'b1}}, 1'b0};

  solve_state_t state, state_nxt;
  logic [WIDTH_WDOG-1:0]   wdog;
  logic [WIDTH_BIN_ID-1:0] cur_bin;
  logic                    wdog_hit;
  logic                    start_acc, conf_inc, dec_inc, bkt_latch, res_set;
  logic [1:0]              res_nxt;

  assign wdog_hit = (wdog == WDOG_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode plus the side effects of each transition.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    conf_inc  = 1'b0;
    dec_inc   = 1'b0;
    bkt_latch = 1'b0;
    res_set   = 1'b0;
    res_nxt   = RES_SAT;
    case (state)
      S_IDLE: begin
        if (start_bin_i) begin
          start_acc = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD:    state_nxt = S_IMPLY;
      S_IMPLY: begin
        if (find_conflict_i) begin
          conf_inc = 1'b1;
          if (cur_lvl_i == '0) begin
            res_set   = 1'b1;
            res_nxt   = RES_UNSAT;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ANALYZE;
          end
        end else if (done_imply_i) begin
          state_nxt = S_DECIDE;
        end else if (wdog_hit) begin
          res_set   = 1'b1;
          res_nxt   = RES_TIMEOUT;
          state_nxt = S_DONE;
        end
      end
      S_DECIDE:  state_nxt = S_W_DECIDE;
      S_W_DECIDE: begin
        if (done_decision_i) begin
          if (all_assigned_i) begin
            res_set   = 1'b1;
            res_nxt   = RES_SAT;
            state_nxt = S_DONE;
          end else begin
            dec_inc   = 1'b1;
            state_nxt = S_IMPLY;
          end
        end else if (wdog_hit) begin
          res_set   = 1'b1;
          res_nxt   = RES_TIMEOUT;
          state_nxt = S_DONE;
        end
      end
      S_ANALYZE: state_nxt = S_W_ANALYZE;
      S_W_ANALYZE: begin
        if (done_analyze_i) begin
          bkt_latch = 1'b1;
          if (bkt_bin_i != cur_bin) begin
            res_set   = 1'b1;
            res_nxt   = RES_BKT_OUT;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_BKT;
          end
        end else if (wdog_hit) begin
          res_set   = 1'b1;
          res_nxt   = RES_TIMEOUT;
          state_nxt = S_DONE;
        end
      end
      S_BKT: begin
        if (done_bkt_cur_bin_i) begin
          state_nxt = S_IMPLY;
        end else if (wdog_hit) begin
          res_set   = 1'b1;
          res_nxt   = RES_TIMEOUT;
          state_nxt = S_DONE;
        end
      end
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Watchdog: restarts on every state change, counts only while waiting on state_list.
  always_ff @(posedge clk) begin
    if (!rst)                       wdog <= '0;
    else if (state_nxt != state)    wdog <= '0;
    else if (is_wait_state(state))  wdog <= wdog + 1'b1;
  end

  // Registered outputs decoded from the next state, plus latched bin/level/result data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_bin_o          <= 1'b0;
      bin_result_o        <= RES_SAT;
      bkt_bin_o           <= '0;
      bkt_lvl_o           <= '0;
      busy_o              <= 1'b0;
      base_lvl_en_o       <= 1'b0;
      load_lvl_en_o       <= 1'b0;
      base_lvl_o          <= '0;
      load_lvl_o          <= '0;
      cur_bin             <= '0;
      start_decision_o    <= 1'b0;
      apply_imply_o       <= 1'b0;
      apply_analyze_o     <= 1'b0;
      apply_bkt_cur_bin_o <= 1'b0;
    end else begin
      busy_o              <= (state_nxt != S_IDLE);
      base_lvl_en_o       <= (state_nxt == S_LOAD);
      load_lvl_en_o       <= (state_nxt == S_LOAD);
      start_decision_o    <= (state_nxt == S_DECIDE);
      apply_imply_o       <= (state_nxt == S_IMPLY);
      apply_analyze_o     <= (state_nxt == S_ANALYZE);
      apply_bkt_cur_bin_o <= (state_nxt == S_BKT);
      done_bin_o          <= (state_nxt == S_DONE);
      if (start_acc) begin
        cur_bin      <= cur_bin_num_i;
        base_lvl_o   <= base_lvl_i;
        load_lvl_o   <= load_lvl_i;
        bin_result_o <= RES_SAT;
      end
      if (res_set)   bin_result_o <= res_nxt;
      if (bkt_latch) begin
        bkt_bin_o <= bkt_bin_i;
        bkt_lvl_o <= bkt_lvl_i;
      end
    end
  end

  sat_counter16 u_dec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (dec_inc),
    .count (n_decisions_o)
  );

  sat_counter16 u_conf_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .en    (conf_inc),
    .count (n_conflicts_o)
  );

endmodule

// File: tb/tb_bin_solve_ctrl.sv
// Self-checking bench for bin_solve_ctrl: directed table, hand sequences and scripted random solves.
module tb_bin_solve_ctrl;
  import sat_engine_pkg::*;

  localparam int WL = 16;
  localparam int WB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_bin_i;
  logic [WB-1:0] cur_bin_num_i;
  logic [WL-1:0] base_lvl_i, load_lvl_i;
  logic          done_bin_o;
  logic [1:0]    bin_result_o;
  logic [WB-1:0] bkt_bin_o;
  logic [WL-1:0] bkt_lvl_o;
  logic          busy_o;
  logic [15:0]   n_decisions_o, n_conflicts_o;
  logic          base_lvl_en_o, load_lvl_en_o;
  logic [WL-1:0] base_lvl_o, load_lvl_o;
  logic          start_decision_o, done_decision_i, all_assigned_i;
  logic [WL-1:0] cur_lvl_i;
  logic          apply_imply_o, done_imply_i, find_conflict_i;
  logic          apply_analyze_o, done_analyze_i;
  logic [WB-1:0] bkt_bin_i;
  logic [WL-1:0] bkt_lvl_i;
  logic          apply_bkt_cur_bin_o, done_bkt_cur_bin_i;

  always #5 clk = ~clk;

  bin_solve_ctrl #(.WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_WDOG(8)) dut (
    .clk(clk), .rst(rst), .start_bin_i(start_bin_i), .cur_bin_num_i(cur_bin_num_i),
    .base_lvl_i(base_lvl_i), .load_lvl_i(load_lvl_i), .done_bin_o(done_bin_o),
    .bin_result_o(bin_result_o), .bkt_bin_o(bkt_bin_o), .bkt_lvl_o(bkt_lvl_o),
    .busy_o(busy_o), .n_decisions_o(n_decisions_o), .n_conflicts_o(n_conflicts_o),
    .base_lvl_en_o(base_lvl_en_o), .load_lvl_en_o(load_lvl_en_o),
    .base_lvl_o(base_lvl_o), .load_lvl_o(load_lvl_o),
    .start_decision_o(start_decision_o), .done_decision_i(done_decision_i),
    .all_assigned_i(all_assigned_i), .cur_lvl_i(cur_lvl_i),
    .apply_imply_o(apply_imply_o), .done_imply_i(done_imply_i),
    .find_conflict_i(find_conflict_i), .apply_analyze_o(apply_analyze_o),
    .done_analyze_i(done_analyze_i), .bkt_bin_i(bkt_bin_i), .bkt_lvl_i(bkt_lvl_i),
    .apply_bkt_cur_bin_o(apply_bkt_cur_bin_o), .done_bkt_cur_bin_i(done_bkt_cur_bin_i)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_overrun(input string name, input int idx, input int size);
    vectors++;
    miscompares++;
    $display("FAIL %s: response #%0d requested, script holds %0d", name, idx, size);
  endfunction

  // Response script for one bin solve: what state_list answers to each request, in order.
  typedef struct packed { logic conf; logic [WL-1:0] lvl; } imp_t;
  typedef struct packed { logic [WB-1:0] bin; logic [WL-1:0] lvl; } ana_t;
  imp_t imp_q[$];
  bit   dec_q[$];
  ana_t ana_q[$];
  int   dly_max  = 2;
  bit   noise_en = 1'b0;

  typedef struct {
    logic [1:0]    res;
    int            ndec, nconf, nbkt, nana, ndecp;
    logic [WB-1:0] bb;
    logic [WL-1:0] bl;
  } exp_t;

  // Reference: walk the script as the solve loop would consume it.
  function automatic exp_t model(input logic [WB-1:0] bin);
    exp_t e;
    int ii = 0, di = 0, ai = 0;
    e = '{res: 2'd0, ndec: 0, nconf: 0, nbkt: 0, nana: 0, ndecp: 0, bb: '0, bl: '0};
    while (ii < imp_q.size()) begin
      if (imp_q[ii].conf) begin
        e.nconf++;
        if (imp_q[ii].lvl == '0) begin e.res = RES_UNSAT; return e; end
        ii++;
        e.nana++;
        if (ana_q[ai].bin != bin) begin
          e.res = RES_BKT_OUT; e.bb = ana_q[ai].bin; e.bl = ana_q[ai].lvl;
          return e;
        end
        ai++;
        e.nbkt++;
      end else begin
        ii++;
        e.ndecp++;
        if (dec_q[di]) begin e.res = RES_SAT; return e; end
        di++;
        e.ndec++;
      end
    end
    return e;
  endfunction

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic clear_resp();
    start_bin_i = 1'b0; done_imply_i = 1'b0; find_conflict_i = 1'b0;
    done_decision_i = 1'b0; all_assigned_i = 1'b0; done_analyze_i = 1'b0;
    done_bkt_cur_bin_i = 1'b0;
  endtask

  // Issue start at a negedge while idle; returns at the negedge of cycle +2.
  task automatic start_bin(input logic [WB-1:0] bin, input logic [WL-1:0] base, input logic [WL-1:0] load);
    start_bin_i = 1'b1; cur_bin_num_i = bin; base_lvl_i = base; load_lvl_i = load;
    @(negedge clk);
    start_bin_i = 1'b0;
    cur_bin_num_i = WB'($urandom); base_lvl_i = WL'($urandom); load_lvl_i = WL'($urandom);
    chk("load_strobes_c1", 32'({base_lvl_en_o, load_lvl_en_o}), 32'd3);
    chk("base_lvl_c1", 32'(base_lvl_o), 32'(base));
    chk("load_lvl_c1", 32'(load_lvl_o), 32'(load));
    chk("busy_c1", 32'(busy_o), 32'd1);
    chk("imply_c1", 32'(apply_imply_o), 32'd0);
    chk("counters_cleared", 32'({n_decisions_o, n_conflicts_o}), 32'd0);
    @(negedge clk);
    chk("load_strobes_c2", 32'({base_lvl_en_o, load_lvl_en_o}), 32'd0);
    chk("imply_c2", 32'(apply_imply_o), 32'd1);
  endtask

  // Play state_list: answer each request from the script after a random delay.
  task automatic serve(input int budget, output bit got_done, output int n_sd, output int n_ana, output int n_bkt);
    int ip = 0, dp = 0, ap = 0;
    int imp_cnt = 0, bkt_cnt = 0, dec_cnt = 0, ana_cnt = 0;
    int imp_dly, bkt_dly, dec_dly, ana_dly;
    bit dec_pend = 1'b0, ana_pend = 1'b0, prev_bkt = 1'b0, prev_sd = 1'b0, prev_an = 1'b0;
    got_done = 1'b0; n_sd = 0; n_ana = 0; n_bkt = 0;
    imp_dly = $urandom_range(0, dly_max); bkt_dly = $urandom_range(0, dly_max);
    dec_dly = $urandom_range(0, dly_max); ana_dly = $urandom_range(0, dly_max);
    for (int c = 0; c < budget; c++) begin
      clear_resp();
      if (done_bin_o) begin got_done = 1'b1; return; end
      chk("level_req_exclusive", 32'(apply_imply_o & apply_bkt_cur_bin_o), 32'd0);
      if (noise_en) begin
        start_bin_i = ($urandom_range(0, 7) == 0);
        cur_bin_num_i = WB'($urandom); base_lvl_i = WL'($urandom); load_lvl_i = WL'($urandom);
        if (!apply_imply_o) begin done_imply_i = 1'($urandom); find_conflict_i = 1'($urandom); end
        if (!dec_pend) begin done_decision_i = 1'($urandom); all_assigned_i = 1'($urandom); end
        if (!ana_pend) begin
          done_analyze_i = 1'($urandom); bkt_bin_i = WB'($urandom); bkt_lvl_i = WL'($urandom);
        end
        if (!apply_bkt_cur_bin_o) done_bkt_cur_bin_i = 1'($urandom);
      end
      if (apply_imply_o) begin
        if (imp_cnt >= imp_dly) begin
          if (ip >= imp_q.size()) begin fail_overrun("imply_script", ip, imp_q.size()); return; end
          find_conflict_i = imp_q[ip].conf;
          cur_lvl_i       = imp_q[ip].lvl;
          done_imply_i    = imp_q[ip].conf ? (noise_en ? 1'($urandom) : 1'b1) : 1'b1;
          ip++;
          imp_cnt = 0; imp_dly = $urandom_range(0, dly_max);
        end else imp_cnt++;
      end
      if (apply_bkt_cur_bin_o && !prev_bkt) n_bkt++;
      prev_bkt = apply_bkt_cur_bin_o;
      if (apply_bkt_cur_bin_o) begin
        if (bkt_cnt >= bkt_dly) begin
          done_bkt_cur_bin_i = 1'b1;
          bkt_cnt = 0; bkt_dly = $urandom_range(0, dly_max);
        end else bkt_cnt++;
      end
      if (dec_pend) begin
        if (dec_cnt >= dec_dly) begin
          if (dp >= dec_q.size()) begin fail_overrun("decide_script", dp, dec_q.size()); return; end
          done_decision_i = 1'b1; all_assigned_i = dec_q[dp]; dp++;
          dec_pend = 1'b0;
        end else dec_cnt++;
      end
      if (start_decision_o) begin
        n_sd++;
        chk("decision_pulse_one_cycle", 32'(prev_sd), 32'd0);
        dec_pend = 1'b1; dec_cnt = 0; dec_dly = $urandom_range(0, dly_max);
      end
      prev_sd = start_decision_o;
      if (ana_pend) begin
        if (ana_cnt >= ana_dly) begin
          if (ap >= ana_q.size()) begin fail_overrun("analyze_script", ap, ana_q.size()); return; end
          done_analyze_i = 1'b1; bkt_bin_i = ana_q[ap].bin; bkt_lvl_i = ana_q[ap].lvl; ap++;
          ana_pend = 1'b0;
        end else ana_cnt++;
      end
      if (apply_analyze_o) begin
        n_ana++;
        chk("analyze_pulse_one_cycle", 32'(prev_an), 32'd0);
        ana_pend = 1'b1; ana_cnt = 0; ana_dly = $urandom_range(0, dly_max);
      end
      prev_an = apply_analyze_o;
      @(negedge clk);
    end
  endtask

  // Run one bin from idle through done and compare against the expectation.
  task automatic run_case(input string tag, input logic [WB-1:0] bin, input logic [WL-1:0] base,
                          input logic [WL-1:0] load, input exp_t e);
    bit got;
    int n_sd, n_ana, n_bkt;
    start_bin(bin, base, load);
    serve(600, got, n_sd, n_ana, n_bkt);
    chk({tag, ":done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, ":result"}, 32'(bin_result_o), 32'(e.res));
      chk({tag, ":n_decisions"}, 32'(n_decisions_o), sat16(e.ndec));
      chk({tag, ":n_conflicts"}, 32'(n_conflicts_o), sat16(e.nconf));
      if (e.res == RES_BKT_OUT) begin
        chk({tag, ":bkt_bin"}, 32'(bkt_bin_o), 32'(e.bb));
        chk({tag, ":bkt_lvl"}, 32'(bkt_lvl_o), 32'(e.bl));
      end
      chk({tag, ":decision_pulses"}, n_sd, e.ndecp);
      chk({tag, ":analyze_pulses"}, n_ana, e.nana);
      chk({tag, ":bkt_requests"}, n_bkt, e.nbkt);
      chk({tag, ":requests_low_at_done"},
          32'({apply_imply_o, apply_bkt_cur_bin_o, start_decision_o, apply_analyze_o}), 32'd0);
      chk({tag, ":base_held"}, 32'(base_lvl_o), 32'(base));
      chk({tag, ":load_held"}, 32'(load_lvl_o), 32'(load));
      @(negedge clk);
      clear_resp();
      chk({tag, ":done_one_cycle"}, 32'(done_bin_o), 32'd0);
      chk({tag, ":idle_after_done"}, 32'(busy_o), 32'd0);
      chk({tag, ":result_held"}, 32'(bin_result_o), 32'(e.res));
    end
  endtask

  task automatic gen_random(input logic [WB-1:0] bin);
    logic [WL-1:0] lvl;
    imp_q.delete(); dec_q.delete(); ana_q.delete();
    for (int s = 0; s < 12; s++) begin
      if (s == 11) begin
        imp_q.push_back('{1'b0, WL'($urandom)}); dec_q.push_back(1'b1); return;
      end
      if ($urandom_range(0, 99) < 30) begin
        lvl = ($urandom_range(0, 5) == 0) ? '0 : WL'($urandom_range(1, 65535));
        imp_q.push_back('{1'b1, lvl});
        if (lvl == '0) return;
        if ($urandom_range(0, 2) == 0) begin
          ana_q.push_back('{bin ^ WB'($urandom_range(1, 1023)), WL'($urandom)}); return;
        end
        ana_q.push_back('{bin, WL'($urandom)});
      end else begin
        imp_q.push_back('{1'b0, WL'($urandom)});
        if ($urandom_range(0, 5) == 0) begin dec_q.push_back(1'b1); return; end
        dec_q.push_back(1'b0);
      end
    end
  endtask

  typedef struct {
    logic [WB-1:0] bin;
    logic [WL-1:0] base, load;
    int            pre;       // non-final decisions before the ending
    int            conf_lvl;  // -1: no conflict
    logic [WB-1:0] abin;
    logic [WL-1:0] alvl;
    logic [1:0]    res;
    int            ndec, nconf, nbkt, nana;
    logic [WB-1:0] bb;
    logic [WL-1:0] bl;
  } vec_t;

  vec_t tbl[7];

  initial begin
    exp_t e;
    bit   got;
    int   cnt;
    #900000;
    $display("FAIL global_time_limit: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit   got;
    int   cnt;
    tbl[0] = '{10'd5,   16'd0,     16'd0,     0, -1,     10'd0,   16'd0,     RES_SAT,     0, 0, 0, 0, 10'd0,   16'd0};
    tbl[1] = '{10'd9,   16'h0010,  16'h0012,  2, -1,     10'd0,   16'd0,     RES_SAT,     2, 0, 0, 0, 10'd0,   16'd0};
    tbl[2] = '{10'd3,   16'd4,     16'd5,     1, 5,      10'd3,   16'd4,     RES_SAT,     1, 1, 1, 1, 10'd0,   16'd0};
    tbl[3] = '{10'd3,   16'd2,     16'd3,     1, 2,      10'd1,   16'd2,     RES_BKT_OUT, 1, 1, 0, 1, 10'd1,   16'd2};
    tbl[4] = '{10'd7,   16'd0,     16'd0,     0, 0,      10'd0,   16'd0,     RES_UNSAT,   0, 1, 0, 0, 10'd0,   16'd0};
    tbl[5] = '{10'h3FF, 16'hFFFF,  16'h8000,  3, 0,      10'd0,   16'd0,     RES_UNSAT,   3, 1, 0, 0, 10'd0,   16'd0};
    tbl[6] = '{10'h200, 16'h1234,  16'h1235,  0, 65535,  10'h1FF, 16'hABCD,  RES_BKT_OUT, 0, 1, 0, 1, 10'h1FF, 16'hABCD};

    rst = 1'b0;
    clear_resp();
    cur_bin_num_i = '0; base_lvl_i = '0; load_lvl_i = '0; cur_lvl_i = '0;
    bkt_bin_i = '0; bkt_lvl_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", 32'(|{done_bin_o, bin_result_o, bkt_bin_o, bkt_lvl_o, busy_o,
        n_decisions_o, n_conflicts_o, base_lvl_en_o, load_lvl_en_o, base_lvl_o, load_lvl_o,
        start_decision_o, apply_imply_o, apply_analyze_o, apply_bkt_cur_bin_o}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset_busy", 32'(busy_o), 32'd0);

    // Directed table.
    noise_en = 1'b0;
    dly_max  = 2;
    for (int t = 0; t < 7; t++) begin
      imp_q.delete(); dec_q.delete(); ana_q.delete();
      for (int k = 0; k < tbl[t].pre; k++) begin
        imp_q.push_back('{1'b0, WL'(k + 1)});
        dec_q.push_back(1'b0);
      end
      if (tbl[t].conf_lvl >= 0) begin
        imp_q.push_back('{1'b1, WL'(tbl[t].conf_lvl)});
        if (tbl[t].conf_lvl != 0) begin
          ana_q.push_back('{tbl[t].abin, tbl[t].alvl});
          if (tbl[t].abin == tbl[t].bin) begin
            imp_q.push_back('{1'b0, 16'd9}); dec_q.push_back(1'b1);
          end
        end
      end else begin
        imp_q.push_back('{1'b0, 16'd1}); dec_q.push_back(1'b1);
      end
      e.res = tbl[t].res; e.ndec = tbl[t].ndec; e.nconf = tbl[t].nconf;
      e.nbkt = tbl[t].nbkt; e.nana = tbl[t].nana; e.bb = tbl[t].bb; e.bl = tbl[t].bl;
      e.ndecp = tbl[t].ndec + ((tbl[t].res == RES_SAT) ? 1 : 0);
      run_case($sformatf("tbl%0d", t), tbl[t].bin, tbl[t].base, tbl[t].load, e);
    end

    // Timeout: no imply response ever arrives.
    start_bin(10'd4, 16'd1, 16'd2);
    cnt = 0; got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_bin_o) begin got = 1'b1; break; end
      if (apply_imply_o) cnt++;
      @(negedge clk);
    end
    chk("timeout:done_seen", 32'(got), 32'd1);
    chk("timeout:imply_cycles", cnt, 255);
    chk("timeout:result", 32'(bin_result_o), 32'(RES_TIMEOUT));
    chk("timeout:imply_dropped", 32'(apply_imply_o), 32'd0);
    @(negedge clk);
    chk("timeout:idle", 32'(busy_o), 32'd0);

    // Reset while waiting for analyze.
    start_bin(10'd3, 16'd10, 16'd12);
    find_conflict_i = 1'b1; cur_lvl_i = 16'd3;
    @(negedge clk);
    clear_resp();
    chk("rst_seq:analyze_pulse", 32'(apply_analyze_o), 32'd1);
    @(negedge clk);
    chk("rst_seq:w_analyze_busy", 32'({busy_o, apply_analyze_o}), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_seq:outputs_zero", 32'(|{done_bin_o, bin_result_o, bkt_bin_o, bkt_lvl_o, busy_o,
        n_decisions_o, n_conflicts_o, base_lvl_en_o, load_lvl_en_o, base_lvl_o, load_lvl_o,
        start_decision_o, apply_imply_o, apply_analyze_o, apply_bkt_cur_bin_o}), 32'd0);
    rst = 1'b1;
    done_analyze_i = 1'b1; bkt_bin_i = 10'd1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_seq:no_done", 32'({done_bin_o, busy_o}), 32'd0);
    end
    clear_resp();

    // Random scripts with noise on unrelated responses and on start_bin_i.
    noise_en = 1'b1;
    dly_max  = 4;
    for (int r = 0; r < 40; r++) begin
      logic [WB-1:0] bin;
      bin = WB'($urandom);
      gen_random(bin);
      e = model(bin);
      run_case($sformatf("rnd%0d", r), bin, WL'($urandom), WL'($urandom), e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
